rng_request_scheduler: RTL and testbench

Shares one block-streaming random-number generator between `NUM_REQ` requesters, such as encryption units needing a 4096-bit random nonce.
- Arbitration is round-robin.
- For a granted requester, the block pulses the generator's trigger for one cycle, then counts exactly `NUM_BLOCKS` valid 32-bit words.
- Each counted word is forwarded to the granted requester only, tagged with a last-word marker.
- After the last word the block releases the generator for the next requester.

---
 rtl/rng_request_scheduler.sv | 128 ++++++++++++
 tb/tb_rng_request_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rng_request_scheduler.sv
// Round-robin scheduler sharing one block-streaming RNG between NUM_REQ requesters.
// Each grant triggers the RNG once and forwards exactly NUM_BLOCKS words to the winner.
module rng_request_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int REGISTER_SIZE = 32,
  parameter int BIT_WIDTH     = 4096
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_in,
  output logic [NUM_REQ-1:0]       grant_out,
  output logic                     busy_out,
  output logic                     rng_trigger_out,
  input  logic [REGISTER_SIZE-1:0] rng_data_in,
  input  logic                     rng_valid_in,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic [NUM_REQ-1:0]       valid_out,
  output logic                     last_out,
  output logic [NUM_REQ-1:0]       done_out
);
  localparam int NUM_BLOCKS = BIT_WIDTH / REGISTER_SIZE;
  localparam int PTR_W      = $clog2(NUM_REQ);
  localparam int CNT_W      = $clog2(NUM_BLOCKS) + 1;

  typedef enum logic [1:0] {IDLE, TRIGGER, STREAM, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   last_ptr;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [CNT_W-1:0]   word_cnt;
  logic               capture;
  logic               last_capture;

  // Only words arriving while streaming are counted; everything else is dropped.
  assign capture      = (state == STREAM) && rng_valid_in;
  assign last_capture = capture && (word_cnt == CNT_W'(NUM_BLOCKS - 1));

  // Search starts just after the previous winner and wraps around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(last_ptr) + i) % NUM_REQ);
      if (!win_found && req_in[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    busy_out        = 1'b0;
    rng_trigger_out = 1'b0;
    done_out        = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_next = TRIGGER;
        end
      end
      TRIGGER: begin
        busy_out        = 1'b1;
        rng_trigger_out = 1'b1;
        state_next      = STREAM;
      end
      STREAM: begin
        busy_out = 1'b1;
        if (last_capture) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy_out   = 1'b1;
        done_out   = grant_out;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant is latched at arbitration and held until the DONE cycle ends.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      grant_out <= '0;
      last_ptr  <= PTR_W'(NUM_REQ - 1);
      word_cnt  <= '0;
    end else begin
      if ((state == IDLE) && win_found) begin
        grant_out <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
        last_ptr  <= win_idx;
        word_cnt  <= '0;
      end else if (state == DONE) begin
        grant_out <= '0;
      end
      if (capture) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_out  <= '0;
      valid_out <= '0;
      last_out  <= 1'b0;
    end else begin
      valid_out <= capture ? grant_out : '0;
      last_out  <= last_capture;
      if (capture) begin
        data_out <= rng_data_in;
      end
    end
  end

endmodule

// File: tb/tb_rng_request_scheduler.sv
// Bench for rng_request_scheduler: random RNG traffic and requests compared against
// a transaction-level model of round-robin choice and per-grant word delivery.
module tb_rng_request_scheduler;
  localparam int NUM_REQ       = 4;
  localparam int REGISTER_SIZE = 32;
  localparam int BIT_WIDTH     = 4096;
  localparam int NUM_BLOCKS    = BIT_WIDTH / REGISTER_SIZE;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic [NUM_REQ-1:0]       req_in;
  logic [NUM_REQ-1:0]       grant_out;
  logic                     busy_out;
  logic                     rng_trigger_out;
  logic [REGISTER_SIZE-1:0] rng_data_in;
  logic                     rng_valid_in;
  logic [REGISTER_SIZE-1:0] data_out;
  logic [NUM_REQ-1:0]       valid_out;
  logic                     last_out;
  logic [NUM_REQ-1:0]       done_out;

  int checks = 0;
  int errors = 0;
  int model_last = NUM_REQ - 1;
  logic [REGISTER_SIZE-1:0] model_data = '0;

  always #5 clk_in = ~clk_in;

  rng_request_scheduler #(
    .NUM_REQ(NUM_REQ),
    .REGISTER_SIZE(REGISTER_SIZE),
    .BIT_WIDTH(BIT_WIDTH)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .req_in(req_in),
    .grant_out(grant_out),
    .busy_out(busy_out),
    .rng_trigger_out(rng_trigger_out),
    .rng_data_in(rng_data_in),
    .rng_valid_in(rng_valid_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .last_out(last_out),
    .done_out(done_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant_out), 0);
    checkOutput({tag, "_busy"}, 32'(busy_out), 0);
    checkOutput({tag, "_trigger"}, 32'(rng_trigger_out), 0);
    checkOutput({tag, "_data"}, data_out, 0);
    checkOutput({tag, "_valid"}, 32'(valid_out), 0);
    checkOutput({tag, "_last"}, 32'(last_out), 0);
    checkOutput({tag, "_done"}, 32'(done_out), 0);
  endtask

  // Winner is the first requesting index after the previous winner, wrapping.
  function automatic int rrPick(input logic [NUM_REQ-1:0] req, input int last);
    int pos;
    pos = last;
    repeat (NUM_REQ) begin
      pos = (pos + 1) % NUM_REQ;
      if (((req >> pos) & 1) != 0) return pos;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [NUM_REQ-1:0] req, input int gap_at,
                               input int drop_at, input int reset_at);
    int winner;
    int words;
    int cycles;
    int gap_left;
    bit gap_used;
    bit drove;
    logic [NUM_REQ-1:0] g;
    req_in       = req;
    rng_valid_in = 1'b1;
    rng_data_in  = $urandom;
    tick();
    winner = rrPick(req, model_last);
    g = NUM_REQ'(1 << winner);
    checkOutput("grant", 32'(grant_out), 32'(g));
    checkOutput("busy_at_grant", 32'(busy_out), 1);
    checkOutput("trigger_pulse", 32'(rng_trigger_out), 1);
    checkOutput("valid_at_trigger", 32'(valid_out), 0);
    model_last = winner;

    rng_valid_in = 1'b1;
    rng_data_in  = $urandom;
    tick();
    checkOutput("trigger_one_cycle", 32'(rng_trigger_out), 0);
    checkOutput("valid_after_trigger", 32'(valid_out), 0);

    words    = 0;
    cycles   = 0;
    gap_left = 0;
    gap_used = 1'b0;
    while (words < NUM_BLOCKS && cycles < 1000) begin
      if (gap_left > 0) begin
        drove = 1'b0;
        gap_left--;
      end else begin
        drove = ($urandom_range(0, 7) != 0);
      end
      rng_valid_in = drove;
      rng_data_in  = $urandom;
      if (drove) begin
        words++;
        model_data = rng_data_in;
      end
      tick();
      cycles++;
      checkOutput("valid", 32'(valid_out), drove ? 32'(g) : 0);
      checkOutput("data", data_out, model_data);
      checkOutput("last", 32'(last_out), 32'(drove && words == NUM_BLOCKS));
      checkOutput("done", 32'(done_out), (words == NUM_BLOCKS) ? 32'(g) : 0);
      checkOutput("grant_held", 32'(grant_out), 32'(g));
      checkOutput("busy_stream", 32'(busy_out), 1);
      checkOutput("no_retrigger", 32'(rng_trigger_out), 0);
      if (words == gap_at && !gap_used) begin
        gap_used = 1'b1;
        gap_left = 5;
      end
      if (words == drop_at) req_in = req_in & ~g;
      if (words == reset_at) begin
        #2 rst_in = 1'b0;
        #1;
        checkAllZero("async_reset");
        model_data = '0;
        model_last = NUM_REQ - 1;
        req_in = '0;
        repeat (2) begin
          rng_valid_in = 1'b1;
          rng_data_in  = $urandom;
          tick();
          checkAllZero("held_reset");
        end
        rst_in = 1'b1;
        repeat (5) begin
          rng_valid_in = 1'b1;
          rng_data_in  = $urandom;
          tick();
          checkOutput("stale_valid", 32'(valid_out), 0);
          checkOutput("stale_busy", 32'(busy_out), 0);
          checkOutput("stale_done", 32'(done_out), 0);
          checkOutput("stale_data", data_out, 0);
        end
        return;
      end
    end
    checkOutput("stream_word_count", 32'(words), NUM_BLOCKS);

    rng_valid_in = 1'b1;
    rng_data_in  = $urandom;
    tick();
    checkOutput("idle_grant", 32'(grant_out), 0);
    checkOutput("idle_busy", 32'(busy_out), 0);
    checkOutput("extra_word_valid", 32'(valid_out), 0);
    checkOutput("idle_last", 32'(last_out), 0);
    checkOutput("idle_done", 32'(done_out), 0);
    checkOutput("idle_data_hold", data_out, model_data);
  endtask

  initial begin
    rst_in       = 1'b1;
    req_in       = '0;
    rng_valid_in = 1'b0;
    rng_data_in  = '0;
    #2 rst_in = 1'b0;
    repeat (3) begin
      req_in       = NUM_REQ'($urandom);
      rng_valid_in = 1'($urandom);
      rng_data_in  = $urandom;
      tick();
      checkAllZero("reset");
    end
    rst_in = 1'b1;
    req_in = '0;
    repeat (4) begin
      rng_valid_in = 1'($urandom);
      rng_data_in  = $urandom;
      tick();
      checkOutput("post_reset_busy", 32'(busy_out), 0);
      checkOutput("post_reset_grant", 32'(grant_out), 0);
      checkOutput("post_reset_valid", 32'(valid_out), 0);
    end

    repeat (5) applyStimulus(4'b1111, -1, -1, -1);

    applyStimulus(4'b0100, 60, -1, -1);

    applyStimulus(4'b1000, -1, 10, -1);
    repeat (5) begin
      tick();
      checkOutput("no_regrant", 32'(grant_out), 0);
      checkOutput("no_regrant_busy", 32'(busy_out), 0);
    end

    applyStimulus(4'b0010, -1, -1, 50);
    applyStimulus(4'b0001, -1, -1, -1);

    repeat (3) begin
      applyStimulus(NUM_REQ'($urandom_range(1, 15)), $urandom_range(0, NUM_BLOCKS - 1),
                    $urandom_range(0, NUM_BLOCKS - 1), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
